// File: rtl/cache_lookup_array.sv
// Tag/data/age store for a 4-way set-associative cache. Each request runs
// IDLE -> COMPARE -> UPDATE: results in COMPARE, line and age commit in UPDATE.
module cache_lookup_array #(
  parameter int INDEX_W = 3,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [31:0]       address_word,
  input  logic              try_read,
  input  logic              try_write,
  input  logic [DATA_W-1:0] write_data,
  input  logic [3:0]        reset_age,
  input  logic [3:0]        increment_age,
  output logic              hit_miss,
  output logic [3:0]        hit_miss_set,
  output logic [7:0]        ages,
  output logic [DATA_W-1:0] read_data,
  output logic              done,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, COMPARE = 2'd1, UPDATE = 2'd2} state_t;

  state_t st;
  assign state = st;

  logic              valid_q [SETS][4];
  logic [TAG_W-1:0]  tag_q   [SETS][4];
  logic [DATA_W-1:0] data_q  [SETS][4];
  logic [1:0]        age_q   [SETS][4];

  logic [31:0]       addr_q;
  logic              is_write_q;
  logic [DATA_W-1:0] wdata_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ltag;
  assign idx  = addr_q[INDEX_W-1:0];
  assign ltag = addr_q[31:INDEX_W];

  logic              hit;
  logic [3:0]        hit_sel;
  logic [3:0]        inv_sel;
  logic [3:0]        old_sel;
  logic [3:0]        victim_sel;
  logic              found_hit;
  logic              found_inv;
  logic              found_old;
  logic [1:0]        max_age;
  logic [7:0]        cur_ages;
  logic [DATA_W-1:0] hit_data;

  // Victim: first invalid way, else the lowest-index way holding the oldest age.
  always_comb begin
    hit_sel   = '0;
    inv_sel   = '0;
    old_sel   = '0;
    found_hit = 1'b0;
    found_inv = 1'b0;
    found_old = 1'b0;
    max_age   = '0;
    cur_ages  = '0;
    hit_data  = '0;
    for (int w = 0; w < 4; w++) begin
      cur_ages[2*w +: 2] = age_q[idx][w];
      if (age_q[idx][w] > max_age) max_age = age_q[idx][w];
      if (valid_q[idx][w] && (tag_q[idx][w] == ltag) && !found_hit) begin
        hit_sel[w] = 1'b1;
        hit_data   = data_q[idx][w];
        found_hit  = 1'b1;
      end
      if (!valid_q[idx][w] && !found_inv) begin
        inv_sel[w] = 1'b1;
        found_inv  = 1'b1;
      end
    end
    for (int w = 0; w < 4; w++) begin
      if ((age_q[idx][w] == max_age) && !found_old) begin
        old_sel[w] = 1'b1;
        found_old  = 1'b1;
      end
    end
    hit        = found_hit;
    victim_sel = found_inv ? inv_sel : old_sel;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      st           <= IDLE;
      hit_miss     <= 1'b0;
      hit_miss_set <= '0;
      ages         <= '0;
      read_data    <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      addr_q       <= '0;
      is_write_q   <= 1'b0;
      wdata_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < 4; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= 2'(w);
        end
      end
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (try_read || try_write) begin
            addr_q     <= address_word;
            is_write_q <= try_write;
            wdata_q    <= write_data;
            st         <= COMPARE;
          end
        end
        COMPARE: begin
          hit_miss     <= hit;
          hit_miss_set <= hit ? hit_sel : victim_sel;
          ages         <= cur_ages;
          read_data    <= (hit && !is_write_q) ? hit_data : '0;
          done         <= 1'b1;
          busy         <= 1'b1;
          st           <= UPDATE;
        end
        UPDATE: begin
          done <= 1'b0;
          for (int w = 0; w < 4; w++) begin
            if (reset_age[w]) begin
              age_q[idx][w] <= 2'd0;
            end else if (increment_age[w] && (age_q[idx][w] != 2'd3)) begin
              age_q[idx][w] <= age_q[idx][w] + 2'd1;
            end
            if (is_write_q && hit_miss_set[w]) begin
              valid_q[idx][w] <= 1'b1;
              tag_q[idx][w]   <= ltag;
              data_q[idx][w]  <= wdata_q;
            end
          end
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
